// File: rtl/max6675_reader.sv
// Read-only SPI master for the MAX6675: waits out the conversion time, clocks one 16-bit frame, latches reading and flags.
// Outputs update one cycle after the last sample with a one-cycle data_valid; no backpressure, a started frame always completes.
module max6675_reader #(
    parameter int SCK_DIV   = 12,
    parameter int CONV_WAIT = 11_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        so,
    output logic        cs_n,
    output logic        sck,
    output logic [15:0] temperature,
    output logic [9:0]  temp_c,
    output logic        open_tc,
    output logic        frame_err,
    output logic        data_valid
);

    localparam int WAIT_W = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;
    localparam int DIV_W  = $clog2(SCK_DIV);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CONV_WAIT - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCK_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        bit_cnt;
    logic              sck_hi;
    logic [15:0]       shift_reg;
    logic              so_meta;
    logic              so_sync;
    logic              div_last;
    logic              unused_d0;

    assign div_last  = (div_cnt == DIV_MAX);
    // D0 is a don't-care bit on the MAX6675 and is shifted in only to complete the frame.
    assign unused_d0 = shift_reg[0];

    // Decoded straight from reset flops so an asynchronous reset deasserts the bus at once.
    assign cs_n = !((state == SETUP) || (state == SHIFT));
    assign sck  = (state == SHIFT) && sck_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so_meta <= 1'b0;
            so_sync <= 1'b0;
        end else begin
            so_meta <= so;
            so_sync <= so_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sck_hi      <= 1'b0;
            shift_reg   <= '0;
            temperature <= '0;
            temp_c      <= '0;
            open_tc     <= 1'b0;
            frame_err   <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Counter saturates so a late enable starts the frame on the very next cycle.
                    if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (enable) begin
                        state   <= SETUP;
                        div_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sck_hi  <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!sck_hi) begin
                            sck_hi <= 1'b1;
                        end else begin
                            // Sample at the end of the high phase, well after the device's falling-edge update.
                            sck_hi    <= 1'b0;
                            shift_reg <= {shift_reg[14:0], so_sync};
                            if (bit_cnt == 4'd15) begin
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    open_tc    <= shift_reg[2];
                    frame_err  <= shift_reg[15] | shift_reg[1];
                    if (!shift_reg[2]) begin
                        temperature <= {4'b0000, shift_reg[14:3]};
                        temp_c      <= shift_reg[14:5];
                    end
                    data_valid <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max6675_reader.sv
// Directed bench for max6675_reader with a behavioural MAX6675 serial model.
module tb_max6675_reader;

    localparam int SCK_DIV   = 4;
    localparam int CONV_WAIT = 100;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        so     = 1'b0;
    logic        cs_n;
    logic        sck;
    logic [15:0] temperature;
    logic [9:0]  temp_c;
    logic        open_tc;
    logic        frame_err;
    logic        data_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    int   cs_low_cnt = 0;
    int   cs_falls   = 0;
    int   sck_rises  = 0;
    int   dv_cnt     = 0;
    int   sck_viol   = 0;
    logic cs_prev    = 1'b1;
    logic sck_prev   = 1'b0;

    logic [15:0] dev_frame = 16'h0000;
    logic [15:0] dev_sr    = 16'h0000;
    logic        dev_cs_q  = 1'b1;
    logic        dev_sck_q = 1'b0;

    max6675_reader #(
        .SCK_DIV   (SCK_DIV),
        .CONV_WAIT (CONV_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .so          (so),
        .cs_n        (cs_n),
        .sck         (sck),
        .temperature (temperature),
        .temp_c      (temp_c),
        .open_tc     (open_tc),
        .frame_err   (frame_err),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;

    // Device model: D15 appears on the cs_n fall, next bit on each sck fall.
    always @(cs_n or sck) begin
        if (cs_n === 1'b0 && dev_cs_q === 1'b1) begin
            dev_sr = dev_frame;
            so     = dev_frame[15];
        end else if (cs_n === 1'b0 && sck === 1'b0 && dev_sck_q === 1'b1) begin
            dev_sr = {dev_sr[14:0], 1'b0};
            so     = dev_sr[15];
        end
        dev_cs_q  = cs_n;
        dev_sck_q = sck;
    end

    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (cs_prev === 1'b1) begin
                cs_falls++;
                cs_low_cnt = 1;
            end else begin
                cs_low_cnt++;
            end
        end
        if (sck === 1'b1 && sck_prev !== 1'b1) sck_rises++;
        if (sck === 1'b1 && cs_n === 1'b1) sck_viol++;
        if (data_valid === 1'b1) dv_cnt++;
        cs_prev  = cs_n;
        sck_prev = sck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_dv(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (data_valid === 1'b1) seen = 1'b1;
        end
        #1;
    endtask

    task automatic wait_cs_low(input int budget, output int n);
        n = 0;
        while (cs_n !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    initial begin
        bit seen;
        int n;
        int r0;
        int dv0;
        int falls0;

        repeat (3) @(negedge clk);
        check("rst_cs_n",    cs_n,        1);
        check("rst_sck",     sck,         0);
        check("rst_temp",    temperature, 0);
        check("rst_temp_c",  temp_c,      0);
        check("rst_open",    open_tc,     0);
        check("rst_err",     frame_err,   0);
        check("rst_dv",      data_valid,  0);

        // Frame 1: 100.00 C
        @(negedge clk);
        dev_frame = 16'h0C80;
        reset     = 1'b1;
        enable    = 1'b1;
        r0        = sck_rises;
        wait_cs_low(1000, n);
        check("f1_idle_wait", n, 100);
        wait_dv(400, seen);
        check("f1_dv_seen",   seen,           1);
        check("f1_cs_low",    cs_low_cnt,     132);
        check("f1_sck_rises", sck_rises - r0, 16);
        check("f1_temp",      temperature,    16'h0190);
        check("f1_temp_c",    temp_c,         100);
        check("f1_open",      open_tc,        0);
        check("f1_err",       frame_err,      0);
        @(negedge clk);
        #1;
        check("f1_dv_one_cycle", data_valid, 0);
        check("f1_dv_count",     dv_cnt,     1);

        // enable held low: no activity, then immediate start once raised
        enable    = 1'b0;
        dev_frame = 16'h0004;
        falls0    = cs_falls;
        dv0       = dv_cnt;
        repeat (500) @(negedge clk);
        #1;
        check("en_low_no_cs", cs_falls, falls0);
        check("en_low_no_dv", dv_cnt,   dv0);
        check("en_low_cs_hi", cs_n,     1);
        enable = 1'b1;
        @(negedge clk);
        #1;
        check("en_high_cs_fall", cs_n, 0);

        // Open thermocouple frame with enable dropped mid-SHIFT
        repeat (30) @(negedge clk);
        check("mid_shift_cs", cs_n, 0);
        enable = 1'b0;
        wait_dv(300, seen);
        check("open_dv_seen", seen,        1);
        check("open_open",    open_tc,     1);
        check("open_err",     frame_err,   0);
        check("open_temp",    temperature, 16'h0190);
        check("open_temp_c",  temp_c,      100);
        enable = 1'b1;

        // D15 and D1 set
        dev_frame = 16'h8002;
        wait_dv(400, seen);
        check("err_dv_seen", seen,        1);
        check("err_err",     frame_err,   1);
        check("err_open",    open_tc,     0);
        check("err_temp",    temperature, 16'h0000);
        check("err_temp_c",  temp_c,      0);

        // Full-scale code
        dev_frame = 16'h7FF8;
        wait_dv(400, seen);
        check("max_dv_seen", seen,        1);
        check("max_temp",    temperature, 16'h0FFF);
        check("max_temp_c",  temp_c,      1023);
        check("max_err",     frame_err,   0);
        check("max_open",    open_tc,     0);

        // Reset during the 8th sck high phase
        dev_frame = 16'h0C80;
        wait_cs_low(400, n);
        check("rst_mid_cs_seen", cs_n, 0);
        r0 = sck_rises;
        n  = 0;
        while ((sck_rises - r0) < 8 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_8th_rise", sck_rises - r0, 8);
        check("rst_mid_sck_hi",   sck,            1);
        dv0   = dv_cnt;
        reset = 1'b0;
        #1;
        check("rst_mid_cs_n",   cs_n,        1);
        check("rst_mid_sck",    sck,         0);
        check("rst_mid_temp",   temperature, 0);
        check("rst_mid_temp_c", temp_c,      0);
        check("rst_mid_open",   open_tc,     0);
        check("rst_mid_err",    frame_err,   0);
        check("rst_mid_dv",     data_valid,  0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        wait_cs_low(1000, n);
        check("rst_rel_idle_wait", n,      100);
        check("rst_rel_no_dv",     dv_cnt, dv0);
        wait_dv(400, seen);
        check("rst_rel_dv_seen", seen,        1);
        check("rst_rel_temp",    temperature, 16'h0190);
        check("rst_rel_temp_c",  temp_c,      100);
        check("sck_while_cs_hi", sck_viol,    0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
